// File: rtl/rv_instr_encoder_if.sv
// Command and instruction-stream handshake bundle for rv_instr_encoder.
// The slave side is the encoder; the master side is the producer of commands and consumer of words.
interface rv_instr_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_kind;
   logic [4:0]  cmd_rd;
   logic [4:0]  cmd_rs1;
   logic [4:0]  cmd_rs2;
   logic [2:0]  cmd_funct3;
   logic [6:0]  cmd_funct7;
   logic [12:0] cmd_imm;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output cmd_valid, cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_funct7, cmd_imm,
      output instr_ready,
      input  cmd_ready, Instruction, instr_valid
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_funct7, cmd_imm,
      input  instr_ready,
      output cmd_ready, Instruction, instr_valid
   );
endinterface

// File: rtl/rv_instr_encoder.sv
// Encodes abstract RV32I commands (R-type, LOAD, STORE, BRANCH) into 32-bit words
// and streams them out through a DEPTH-entry FIFO with valid/ready on both sides.
module rv_instr_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   rv_instr_encoder_if.slave   bus,
   output logic [CNT_W-1:0]    instr_count,
   output logic                misalign_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      KIND_R      = 2'b00,
      KIND_LOAD   = 2'b01,
      KIND_STORE  = 2'b10,
      KIND_BRANCH = 2'b11
   } kind_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [31:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic [31:0] word;
   kind_e       kind;

   assign kind  = kind_e'(bus.cmd_kind);
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = bus.cmd_valid && !full;
   assign pop   = bus.instr_ready && !empty;

   assign bus.cmd_ready   = !full;
   assign bus.instr_valid = !empty;
   assign bus.Instruction = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

   // NOTE: every path assigns word, so this block stays purely combinational (no latch).
   always_comb begin
      word = 32'd0;
      unique case (kind)
         KIND_R:      word = {bus.cmd_funct7, bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                              bus.cmd_rd, OP_R};
         KIND_LOAD:   word = {bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3,
                              bus.cmd_rd, OP_LOAD};
         KIND_STORE:  word = {bus.cmd_imm[11:5], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                              bus.cmd_imm[4:0], OP_STORE};
         KIND_BRANCH: word = {bus.cmd_imm[12], bus.cmd_imm[10:5], bus.cmd_rs2, bus.cmd_rs1,
                              bus.cmd_funct3, bus.cmd_imm[4:1], bus.cmd_imm[11], OP_BRANCH};
         default:     word = 32'd0;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         instr_count  <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr      <= rd_ptr + (AW+1)'(1);
            instr_count <= instr_count + CNT_W'(1);
         end
         if (push && kind == KIND_BRANCH && bus.cmd_imm[0]) misalign_err <= 1'b1;
      end
   end

   // NOTE: storage is not reset; the output mux forces zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= word;
   end
endmodule
